// File: rtl/alu_sched.sv
// Round-robin scheduler for the shared ALU: issues one function word at a time,
// waits for the ack with a bounded timeout and owns the architectural C/N/Z/V flags.
module alu_sched #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [31:0] fnct_0,
  input  logic [31:0] fnct_1,
  input  logic        upd_0,
  input  logic        upd_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic        done_0,
  output logic        done_1,
  output logic [31:0] rsp_data,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err,
  output logic [31:0] fnct_out,
  output logic        cf_curr,
  output logic        nf_curr,
  output logic        zf_curr,
  output logic        vf_curr,
  input  logic [31:0] alu_out,
  input  logic        alu_ack,
  input  logic        cf,
  input  logic        nf,
  input  logic        zf,
  input  logic        vf
);

  typedef enum logic [1:0] {StIdle, StWait, StGap} state_e;

  localparam logic [7:0] CntMax = 8'(TIMEOUT - 1);

  state_e     state_q;
  logic [7:0] cnt_q;
  logic       last_gnt_q;
  logic       owner_q;
  logic       upd_q;
  logic [3:0] flags_q;
  logic       pick_1;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign pick_1 = req_1 && (!req_0 || !last_gnt_q);

  assign cf_curr = flags_q[3];
  assign nf_curr = flags_q[2];
  assign zf_curr = flags_q[1];
  assign vf_curr = flags_q[0];

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      last_gnt_q <= 1'b1;
      owner_q    <= 1'b0;
      upd_q      <= 1'b0;
      flags_q    <= 4'd0;
      gnt_0      <= 1'b0;
      gnt_1      <= 1'b0;
      done_0     <= 1'b0;
      done_1     <= 1'b0;
      rsp_data   <= 32'd0;
      rsp_flags  <= 4'd0;
      rsp_err    <= 1'b0;
      fnct_out   <= 32'd0;
    end else begin
      gnt_0  <= 1'b0;
      gnt_1  <= 1'b0;
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_0 || req_1) begin
            state_q    <= StWait;
            owner_q    <= pick_1;
            last_gnt_q <= pick_1;
            upd_q      <= pick_1 ? upd_1 : upd_0;
            fnct_out   <= pick_1 ? fnct_1 : fnct_0;
            gnt_0      <= !pick_1;
            gnt_1      <= pick_1;
            cnt_q      <= 8'd0;
          end
        end
        StWait: begin
          // An ack on the last allowed cycle still counts as a normal completion.
          if (alu_ack || (cnt_q == CntMax)) begin
            state_q  <= StGap;
            fnct_out <= 32'd0;
            done_0   <= !owner_q;
            done_1   <= owner_q;
            if (alu_ack) begin
              rsp_data  <= alu_out;
              rsp_flags <= {cf, nf, zf, vf};
              rsp_err   <= 1'b0;
              if (upd_q) begin
                flags_q <= {cf, nf, zf, vf};
              end
            end else begin
              rsp_data  <= 32'd0;
              rsp_flags <= 4'd0;
              rsp_err   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        StGap: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sched.sv
// Randomized scoreboard bench for alu_sched: a reference model predicts grants,
// responses and flag state; a monitor checks every done pulse against the queue.
module tb_alu_sched;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        req_0 = 1'b0, req_1 = 1'b0;
  logic [31:0] fnct_0 = '0, fnct_1 = '0;
  logic        upd_0 = 1'b0, upd_1 = 1'b0;
  logic        gnt_0, gnt_1, done_0, done_1, rsp_err;
  logic [31:0] rsp_data, fnct_out;
  logic [3:0]  rsp_flags;
  logic        cf_curr, nf_curr, zf_curr, vf_curr;
  logic [31:0] alu_out = '0;
  logic        alu_ack = 1'b0;
  logic        cf = 1'b0, nf = 1'b0, zf = 1'b0, vf = 1'b0;

  alu_sched #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_0(req_0), .req_1(req_1), .fnct_0(fnct_0), .fnct_1(fnct_1),
    .upd_0(upd_0), .upd_1(upd_1), .gnt_0(gnt_0), .gnt_1(gnt_1),
    .done_0(done_0), .done_1(done_1), .rsp_data(rsp_data), .rsp_flags(rsp_flags),
    .rsp_err(rsp_err), .fnct_out(fnct_out),
    .cf_curr(cf_curr), .nf_curr(nf_curr), .zf_curr(zf_curr), .vf_curr(vf_curr),
    .alu_out(alu_out), .alu_ack(alu_ack), .cf(cf), .nf(nf), .zf(zf), .vf(vf)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          owner;
    logic [31:0] data;
    logic [3:0]  flags;
    bit          err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state
  bit          m_last;
  logic [3:0]  m_flags;
  logic [31:0] m_rsp_data;
  logic [3:0]  m_rsp_flags;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_last      = 1'b1;
    m_flags     = 4'd0;
    m_rsp_data  = 32'd0;
    m_rsp_flags = 4'd0;
  endtask

  function automatic logic [31:0] all_ctrl();
    return {19'd0, gnt_0, gnt_1, done_0, done_1, rsp_err, rsp_flags,
            cf_curr, nf_curr, zf_curr, vf_curr};
  endfunction

  // Monitor: every done pulse must match the oldest expected response.
  always @(negedge clk) begin
    if (rst_b && (done_0 || done_1)) begin
      if (sb.size() == 0) begin
        check("unexpected_done", {30'd0, done_1, done_0}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_owner", {30'd0, done_1, done_0}, e.owner ? 32'd2 : 32'd1);
        check("rsp_data", rsp_data, e.data);
        check("rsp_flags_err", {27'd0, rsp_err, rsp_flags}, {27'd0, e.err, e.flags});
        check("gap_fnct_zero", fnct_out, 32'd0);
      end
    end
  end

  // delay < 0 means the ALU never acks; otherwise ack in WAIT cycle index 'delay'.
  task automatic do_op(input bit r0, input bit r1, input logic [31:0] f0,
                       input logic [31:0] f1, input bit u0, input bit u1,
                       input int delay, input logic [31:0] d, input logic [3:0] fl);
    bit   win;
    bit   got;
    bit   timeout;
    int   lat;
    exp_t e;
    win     = (r0 && r1) ? !m_last : r1;
    m_last  = win;
    timeout = (delay < 0) || (delay >= TO);
    e.owner = win;
    if (timeout) begin
      e.data = 32'd0; e.flags = 4'd0; e.err = 1'b1;
    end else begin
      e.data = d; e.flags = fl; e.err = 1'b0;
      if (win ? u1 : u0) m_flags = fl;
    end
    m_rsp_data  = e.data;
    m_rsp_flags = e.flags;
    sb.push_back(e);

    req_0 = r0; req_1 = r1; fnct_0 = f0; fnct_1 = f1; upd_0 = u0; upd_1 = u1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      got = gnt_0 || gnt_1;
    end
    req_0 = 1'b0; req_1 = 1'b0;
    if (!got) begin
      check("gnt_timeout", 32'd0, 32'd1);
      void'(sb.pop_back());
      return;
    end
    check("gnt", {30'd0, gnt_1, gnt_0}, win ? 32'd2 : 32'd1);
    check("fnct_out", fnct_out, win ? f1 : f0);

    got = 1'b0;
    lat = 0;
    for (int i = 1; i <= TO + 4 && !got; i++) begin
      if (!timeout && (i - 1 == delay)) begin
        alu_ack = 1'b1; alu_out = d; {cf, nf, zf, vf} = fl;
      end else begin
        alu_ack = 1'b0; alu_out = $urandom; {cf, nf, zf, vf} = 4'($urandom);
      end
      @(posedge clk); #1;
      if (i < TO && !done_0 && !done_1) check("fnct_hold", fnct_out, win ? f1 : f0);
      if (done_0 || done_1) begin
        got = 1'b1;
        lat = i;
      end
    end
    alu_ack = 1'b0;
    check("done_latency", lat, timeout ? TO : delay + 1);
    check("flags_curr", {28'd0, cf_curr, nf_curr, zf_curr, vf_curr}, {28'd0, m_flags});
    @(posedge clk); #1;
  endtask

  task automatic spurious_ack();
    alu_ack = 1'b1; alu_out = 32'hFFFF_FFFF; {cf, nf, zf, vf} = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    alu_ack = 1'b0;
    check("spur_rsp_data", rsp_data, m_rsp_data);
    check("spur_flags", {24'd0, rsp_flags, cf_curr, nf_curr, zf_curr, vf_curr},
          {24'd0, m_rsp_flags, m_flags});
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_wait();
    bit got;
    req_0 = 1'b1; fnct_0 = 32'hAAAA_AAAA; upd_0 = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      @(posedge clk); #1;
      got = gnt_0 || gnt_1;
    end
    req_0 = 1'b0;
    check("rst_pre_gnt", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    rst_b = 1'b0;
    #1;
    check("rst_ctrl_zero", all_ctrl(), 32'd0);
    check("rst_data_zero", rsp_data, 32'd0);
    check("rst_fnct_zero", fnct_out, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_b = 1'b1;
    repeat (TO + 3) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    #12;
    check("reset_ctrl", all_ctrl(), 32'd0);
    check("reset_fnct", fnct_out, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Single op with flag update; ALU acks 2 cycles after fnct_out
    do_op(1, 0, 32'hAAAA_AAAA, 32'h0, 1, 0, 2, 32'h1234_5678, 4'b1100);
    // Aux op without flag update
    do_op(0, 1, 32'h0, 32'h5555_0001, 0, 0, 0, 32'h0000_0042, 4'b0010);
    // Round robin with both requesting
    for (int i = 0; i < 4; i++) do_op(1, 1, 32'h100 + i, 32'h200 + i, 0, 0, 0, 32'(i), 4'(i));
    // Timeout, then ack on the last allowed WAIT cycle
    do_op(1, 0, 32'hDEAD_0001, 32'h0, 1, 0, -1, 32'h0, 4'h0);
    do_op(1, 0, 32'hDEAD_0002, 32'h0, 1, 0, TO - 1, 32'hCAFE_F00D, 4'b0101);
    spurious_ack();
    reset_mid_wait();
    do_op(1, 1, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1, 1, 1, 32'h0BAD_BEEF, 4'b1001);

    for (int k = 0; k < 30; k++) begin
      int m;
      int dly;
      m   = $urandom_range(1, 3);
      dly = ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, TO - 1);
      do_op(m[0], m[1], 32'($urandom_range(1, 32'h7FFF_FFFF)),
            32'($urandom_range(1, 32'h7FFF_FFFF)), 1'($urandom), 1'($urandom),
            dly, $urandom, 4'($urandom));
    end

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
